// File: rtl/seg7_2421_pkg.sv
// seg7_2421_pkg: segment patterns and 2421-code helpers shared by the display driver.
package seg7_2421_pkg;
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   function automatic logic is_valid_2421(input logic [3:0] code);
      return code <= 4'd4 || code >= 4'd11;
   endfunction

   // Upper half of the 2421 code space sits 6 above its binary value.
   function automatic logic [3:0] dec_2421(input logic [3:0] code);
      return code[3] ? code - 4'd6 : code;
   endfunction
endpackage

// File: rtl/seg7_2421_decode.sv
// seg7_2421_decode: one 2421 digit to its active-high gfedcba pattern plus a validity flag.
module seg7_2421_decode
   import seg7_2421_pkg::*;
(
   input  logic [3:0] i_code,
   output logic [6:0] o_seg,
   output logic       o_valid
);
   always_comb begin
      o_valid = is_valid_2421(i_code);
      case (dec_2421(i_code))
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_DASH;
      endcase
   end
endmodule

// File: rtl/seg7_2421_scan.sv
// seg7_2421_scan: multiplexed 7-segment driver for a frame of 2421 digits with
// leading-zero blanking, invalid-code dashes and a sticky overflow on the top dp.
module seg7_2421_scan
   import seg7_2421_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 100000,
   parameter bit ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic                    blank_lz,
   input  logic                    ovf_in,
   input  logic                    ovf_clr,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    err
);
   localparam int   PW  = $clog2(SCAN_DIV);
   localparam int   IW  = $clog2(NUM_DIGITS);
   localparam logic POL = ACTIVE_LOW;

   logic [PW-1:0]                r_presc;
   logic [IW-1:0]                r_idx;
   logic [NUM_DIGITS-1:0][3:0]   r_frame;
   logic                         r_ovf;
   logic                         r_err;
   logic [6:0]                   r_seg;
   logic                         r_dp;
   logic [NUM_DIGITS-1:0]        r_an;
   logic [6:0]                   w_pat;
   logic [6:0]                   w_seg;
   logic                         w_valid;
   logic                         w_wrap;
   logic                         w_top;
   logic [NUM_DIGITS-1:0]        w_zero;
   logic [NUM_DIGITS-1:0]        w_lz;
   logic [NUM_DIGITS-1:0]        w_inv;

   seg7_2421_decode u_dec (
      .i_code  (r_frame[r_idx]),
      .o_seg   (w_pat),
      .o_valid (w_valid)
   );

   // Leading-zero mask propagates down from the top digit; digit 0 always shows.
   always_comb begin
      w_zero = '0;
      w_inv  = '0;
      w_lz   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         w_zero[i] = r_frame[i] == 4'd0;
         w_inv[i]  = !is_valid_2421(r_frame[i]);
      end
      w_lz[NUM_DIGITS-1] = w_zero[NUM_DIGITS-1];
      for (int i = NUM_DIGITS - 2; i > 0; i--) w_lz[i] = w_zero[i] & w_lz[i+1];
   end

   assign w_wrap = r_presc == PW'(SCAN_DIV - 1);
   assign w_top  = r_idx == IW'(NUM_DIGITS - 1);
   assign w_seg  = !w_valid ? SEG_DASH : (blank_lz && w_lz[r_idx]) ? SEG_BLANK : w_pat;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_presc <= '0;
         r_idx   <= '0;
         r_frame <= '0;
         r_ovf   <= 1'b0;
         r_err   <= 1'b0;
         r_seg   <= {7{POL}} ^ SEG_BLANK;
         r_dp    <= POL;
         r_an    <= {NUM_DIGITS{POL}};
      end else begin
         r_presc <= w_wrap ? '0 : r_presc + 1'b1;
         if (w_wrap) r_idx <= w_top ? '0 : r_idx + 1'b1;
         if (load) r_frame <= digits_in;
         r_ovf   <= ovf_in | (r_ovf & ~ovf_clr);
         r_err   <= |w_inv;
         r_seg   <= {7{POL}} ^ w_seg;
         r_dp    <= POL ^ (w_top & r_ovf);
         // Anodes stay dark for the first cycle of every slot to hide ghosting.
         r_an    <= {NUM_DIGITS{POL}} ^ ((r_presc == '0) ? '0 : NUM_DIGITS'(1) << r_idx);
      end
   end

   assign seg = r_seg;
   assign dp  = r_dp;
   assign an  = r_an;
   assign err = r_err;
endmodule

// File: tb/tb_seg7_2421_scan.sv
// tb_seg7_2421_scan: scoreboard bench; a reference model queues the expected
// outputs for each edge and every test pops and compares them after the edge.
module tb_seg7_2421_scan;
   logic        clk = 1'b0;
   logic        reset, load, blank_lz, ovf_in, ovf_clr;
   logic [15:0] digits_in;
   logic [6:0]  seg;
   logic        dp, err;
   logic [3:0]  an;

   seg7_2421_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .reset(reset), .load(load), .digits_in(digits_in), .blank_lz(blank_lz),
      .ovf_in(ovf_in), .ovf_clr(ovf_clr), .seg(seg), .dp(dp), .an(an), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [6:0] seg;
      logic       dp;
      logic [3:0] an;
      logic       err;
   } exp_t;

   exp_t       q[$];
   exp_t       e;
   logic [6:0] tbl[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h40, 7'h40, 7'h40,
                           7'h40, 7'h40, 7'h40, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   logic [3:0] m_fr[4];
   int         m_p, m_i;
   bit         m_ovf;
   int         tests = 0, fails = 0;

   function automatic exp_t model_out();
      exp_t r;
      bit   hz = 1'b1;
      for (int j = 3; j >= m_i; j--) if (m_fr[j] != 4'd0) hz = 1'b0;
      r.seg = (blank_lz && hz && m_i != 0) ? 7'h00 : tbl[m_fr[m_i]];
      r.dp  = (m_i == 3) && m_ovf;
      r.an  = (m_p == 0) ? 4'b0000 : 4'(1 << m_i);
      r.err = 1'b0;
      for (int j = 0; j < 4; j++) if (tbl[m_fr[j]] == 7'h40) r.err = 1'b1;
      return r;
   endfunction

   task automatic tick();
      exp_t x;
      if (reset) begin
         x = '0;
         for (int j = 0; j < 4; j++) m_fr[j] = 4'd0;
         m_p = 0; m_i = 0; m_ovf = 1'b0;
      end else begin
         x = model_out();
         if (load) for (int j = 0; j < 4; j++) m_fr[j] = digits_in[4*j +: 4];
         m_ovf = ovf_in ? 1'b1 : ovf_clr ? 1'b0 : m_ovf;
         if (m_p == 3) begin m_p = 0; m_i = (m_i + 1) % 4; end
         else m_p++;
      end
      q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; load = 1'b0; blank_lz = 1'b0; ovf_in = 1'b0; ovf_clr = 1'b0; digits_in = '0;
      for (int n = 0; n < 3; n++) begin
         tick(); e = q.pop_front(); tests++;
         if ({seg, dp, an, err} !== e) begin
            fails++;
            $display("FAIL reset: got seg=%h dp=%b an=%b err=%b, expected seg=%h dp=%b an=%b err=%b",
                     seg, dp, an, err, e.seg, e.dp, e.an, e.err);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_idle_scan();
      for (int n = 0; n < 20; n++) begin
         tick(); e = q.pop_front(); tests++;
         if ({seg, dp, an, err} !== e) begin
            fails++;
            $display("FAIL idle_scan cyc %0d: got seg=%h dp=%b an=%b err=%b, expected seg=%h dp=%b an=%b err=%b",
                     n, seg, dp, an, err, e.seg, e.dp, e.an, e.err);
         end
      end
   endtask

   task automatic test_digits(input logic [15:0] d, input logic blz, input int cycles, input string name);
      digits_in = d; blank_lz = blz; load = 1'b1;
      for (int n = 0; n < cycles; n++) begin
         tick(); load = 1'b0; e = q.pop_front(); tests++;
         if ({seg, dp, an, err} !== e) begin
            fails++;
            $display("FAIL %s cyc %0d: got seg=%h dp=%b an=%b err=%b, expected seg=%h dp=%b an=%b err=%b",
                     name, n, seg, dp, an, err, e.seg, e.dp, e.an, e.err);
         end
      end
   endtask

   task automatic test_overflow();
      for (int ph = 0; ph < 3; ph++) begin
         ovf_in  = ph != 2;
         ovf_clr = ph != 0;
         for (int n = 0; n < 16; n++) begin
            tick(); ovf_in = 1'b0; ovf_clr = 1'b0; e = q.pop_front(); tests++;
            if ({seg, dp, an, err} !== e) begin
               fails++;
               $display("FAIL overflow ph %0d cyc %0d: got seg=%h dp=%b an=%b err=%b, expected seg=%h dp=%b an=%b err=%b",
                        ph, n, seg, dp, an, err, e.seg, e.dp, e.an, e.err);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int guard = 0;
      ovf_in = 1'b1;
      tick(); ovf_in = 1'b0; void'(q.pop_front());
      while (!(m_i == 2 && m_p == 1) && guard < 64) begin
         tick(); void'(q.pop_front()); guard++;
      end
      tests++;
      if (guard >= 64) begin
         fails++;
         $display("FAIL reset_mid: slot 2 not reached, got idx=%0d expected idx=2", m_i);
      end
      reset = 1'b1; load = 1'b1; ovf_in = 1'b1; digits_in = 16'hFFFF;
      for (int n = 0; n < 9; n++) begin
         tick(); reset = 1'b0; load = 1'b0; ovf_in = 1'b0; e = q.pop_front(); tests++;
         if ({seg, dp, an, err} !== e) begin
            fails++;
            $display("FAIL reset_mid cyc %0d: got seg=%h dp=%b an=%b err=%b, expected seg=%h dp=%b an=%b err=%b",
                     n, seg, dp, an, err, e.seg, e.dp, e.an, e.err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle_scan();
      test_digits(16'hFB40, 1'b0, 18, "digits_9540");
      test_digits(16'h0013, 1'b1, 16, "blank_0013");
      test_digits(16'h0000, 1'b1, 16, "blank_all_zero");
      test_digits(16'h0013, 1'b0, 8, "noblank_0013");
      test_digits(16'h0643, 1'b1, 16, "invalid_digit2");
      test_digits(16'h1234, 1'b0, 16, "valid_reload");
      test_overflow();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
